// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-port bundle for the byte-wide memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned DATA_LEN = 32
);
  logic                rollback;
  // Instruction fetch channel
  logic                if_valid;
  logic [ADDR_LEN-1:0] if_addr;
  logic                if_done;
  logic [DATA_LEN-1:0] if_data;
  // Load/store channel
  logic                ls_valid;
  logic                ls_wr;
  logic [1:0]          ls_size;
  logic                ls_signed;
  logic [ADDR_LEN-1:0] ls_addr;
  logic [DATA_LEN-1:0] ls_wdata;
  logic                ls_done;
  logic [DATA_LEN-1:0] ls_rdata;
  // Byte-wide RAM port
  logic [7:0]          mem_din;
  logic [7:0]          mem_dout;
  logic [ADDR_LEN-1:0] mem_a;
  logic                mem_wr;

  modport slave (
    input  rollback,
    input  if_valid, if_addr,
    output if_done, if_data,
    input  ls_valid, ls_wr, ls_size, ls_signed, ls_addr, ls_wdata,
    output ls_done, ls_rdata,
    input  mem_din,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output rollback,
    output if_valid, if_addr,
    input  if_done, if_data,
    output ls_valid, ls_wr, ls_size, ls_signed, ls_addr, ls_wdata,
    input  ls_done, ls_rdata,
    output mem_din,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide RAM port between instruction
// fetch (4-byte reads) and the load/store path (1/2/4-byte loads and stores).
// Requests are split into byte beats; load data is assembled little-endian.
module mem_arbiter #(
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned DATA_LEN = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StIfRd, StLsRd, StLsWr, StDone} state_e;

  state_e              state_q;
  logic                last_ls_q;   // 1: previous grant went to LS
  logic [2:0]          cnt_q;       // edges since accept, minus one
  logic [2:0]          beats_q;     // N: 1, 2 or 4
  logic                sgn_q;
  logic [ADDR_LEN-1:0] base_q;
  logic [31:0]         wdata_q;
  logic [23:0]         rbuf_q;      // bytes 0..2 collected so far

  logic       grant_if;
  logic [2:0] ls_beats;
  logic [2:0] nxt;
  logic [7:0] nxt_wbyte;
  logic [31:0] rd_word;

  // Arbitration and beat bookkeeping
  always_comb begin
    grant_if = bus.if_valid && (!bus.ls_valid || last_ls_q);
    unique case (bus.ls_size)
      2'd0:    ls_beats = 3'd1;
      2'd1:    ls_beats = 3'd2;
      default: ls_beats = 3'd4;
    endcase
    nxt = cnt_q + 3'd1;
    case (nxt)
      3'd1:    nxt_wbyte = wdata_q[15:8];
      3'd2:    nxt_wbyte = wdata_q[23:16];
      3'd3:    nxt_wbyte = wdata_q[31:24];
      default: nxt_wbyte = 8'h00;
    endcase
  end

  // Final load word: merge the byte arriving now and extend per size/sign
  always_comb begin
    case (beats_q)
      3'd1:    rd_word = {{24{sgn_q & bus.mem_din[7]}}, bus.mem_din};
      3'd2:    rd_word = {{16{sgn_q & bus.mem_din[7]}}, bus.mem_din, rbuf_q[7:0]};
      default: rd_word = {bus.mem_din, rbuf_q};
    endcase
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_ls_q    <= 1'b1;
      cnt_q        <= '0;
      beats_q      <= '0;
      sgn_q        <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      bus.if_done  <= 1'b0;
      bus.if_data  <= '0;
      bus.ls_done  <= 1'b0;
      bus.ls_rdata <= '0;
      bus.mem_a    <= '0;
      bus.mem_wr   <= 1'b0;
      bus.mem_dout <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!bus.rollback && (bus.if_valid || bus.ls_valid)) begin
            cnt_q <= '0;
            if (grant_if) begin
              state_q   <= StIfRd;
              last_ls_q <= 1'b0;
              beats_q   <= 3'd4;
              sgn_q     <= 1'b0;
              base_q    <= bus.if_addr;
              bus.mem_a <= bus.if_addr;
            end else begin
              last_ls_q <= 1'b1;
              beats_q   <= ls_beats;
              sgn_q     <= bus.ls_signed;
              base_q    <= bus.ls_addr;
              wdata_q   <= bus.ls_wdata[31:0];
              bus.mem_a <= bus.ls_addr;
              if (bus.ls_wr) begin
                state_q      <= StLsWr;
                bus.mem_wr   <= 1'b1;
                bus.mem_dout <= bus.ls_wdata[7:0];
              end else begin
                state_q <= StLsRd;
              end
            end
          end
        end
        StIfRd, StLsRd: begin
          if (bus.rollback) begin
            // Speculative read dropped; partial bytes are simply abandoned
            state_q   <= StIdle;
            bus.mem_a <= '0;
          end else begin
            cnt_q <= nxt;
            if (nxt < beats_q) bus.mem_a <= base_q + ADDR_LEN'(nxt);
            else               bus.mem_a <= '0;
            if (cnt_q == beats_q) begin
              state_q <= StDone;
              if (state_q == StIfRd) begin
                bus.if_done <= 1'b1;
                bus.if_data <= DATA_LEN'(rd_word);
              end else begin
                bus.ls_done  <= 1'b1;
                bus.ls_rdata <= DATA_LEN'(rd_word);
              end
            end else begin
              // Byte k arrives two edges after its address was issued
              case (cnt_q)
                3'd1:    rbuf_q[7:0]   <= bus.mem_din;
                3'd2:    rbuf_q[15:8]  <= bus.mem_din;
                3'd3:    rbuf_q[23:16] <= bus.mem_din;
                default: ;
              endcase
            end
          end
        end
        StLsWr: begin
          // Stores are never flushed: rollback is ignored here
          cnt_q <= nxt;
          if (nxt < beats_q) begin
            bus.mem_a    <= base_q + ADDR_LEN'(nxt);
            bus.mem_dout <= nxt_wbyte;
          end else begin
            state_q      <= StDone;
            bus.mem_a    <= '0;
            bus.mem_dout <= '0;
            bus.mem_wr   <= 1'b0;
            bus.ls_done  <= 1'b1;
          end
        end
        StDone: begin
          state_q     <= StIdle;
          bus.if_done <= 1'b0;
          bus.ls_done <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
